hash_round_ctrl: RTL

HASH_ROUND_CTRL -- requirements
Module: hash_round_ctrl

---
 rtl/hash_round_ctrl_pkg.sv | 30 +++
 rtl/hash_round_ctrl_xor_shift.sv | 22 ++
 rtl/hash_round_ctrl.sv | 85 ++++++++
 3 files changed

// File: rtl/hash_round_ctrl_pkg.sv
// Shared types and constants for the nibble hash round controller.
// Holds the FSM encoding, the 4-bit S-box and the nibble rotate helper.
package hash_round_ctrl_pkg;

  localparam int NIBBLES = 8;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_e;

  // Index 0 is the rightmost entry.
  localparam logic [15:0][3:0] SBOX = {
    4'h2, 4'h1, 4'h7, 4'h4,
    4'h8, 4'hF, 4'hE, 4'h3,
    4'hD, 4'hA, 4'h0, 4'h9,
    4'hB, 4'h6, 4'h5, 4'hC
  };

  function automatic logic [3:0] rotl4(
    input logic [3:0] x,
    input logic [1:0] r
  );
    logic [7:0] d;
    d = {x, x} << r;
    return d[7:4];
  endfunction

endpackage

// File: rtl/hash_round_ctrl_xor_shift.sv
// One hash round: rewrite nibble cnt of H from its upper neighbour.
// Purely combinational; the caller registers the result.
module hash_round_ctrl_xor_shift
  import hash_round_ctrl_pkg::*;
(
  input  logic [31:0] h_i,
  input  logic [3:0]  s_i,
  input  logic [2:0]  cnt_i,
  output logic [31:0] h_o
);

  logic [2:0] nxt;
  logic [3:0] src;

  always_comb begin
    h_o = h_i;
    nxt = cnt_i + 3'd1;
    src = h_i[{nxt, 2'b00} +: 4];
    h_o[{cnt_i, 2'b00} +: 4] = rotl4(src ^ s_i, cnt_i[2:1]);
  end

endmodule

// File: rtl/hash_round_ctrl.sv
// Nibble-serial hash controller: accept, eight rounds, optional digest.
// H persists across nibbles and reloads IV after a digest or abort.
module hash_round_ctrl
  import hash_round_ctrl_pkg::*;
#(
  parameter logic [31:0] IV = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [3:0]  msg_nibble,
  input  logic        msg_last,
  input  logic        abort,
  output logic [31:0] digest,
  output logic        digest_valid,
  output logic        busy
);

  state_e      state_q;
  logic [31:0] h_q;
  logic [31:0] h_d;
  logic [2:0]  cnt_q;
  logic [3:0]  s_q;
  logic        last_q;
  logic [31:0] digest_q;
  logic        dv_q;

  hash_round_ctrl_xor_shift u_round (
    .h_i   (h_q),
    .s_i   (s_q),
    .cnt_i (cnt_q),
    .h_o   (h_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      h_q      <= IV;
      cnt_q    <= '0;
      s_q      <= '0;
      last_q   <= 1'b0;
      digest_q <= '0;
      dv_q     <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        h_q     <= IV;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (msg_valid) begin
              s_q     <= SBOX[msg_nibble];
              last_q  <= msg_last;
              cnt_q   <= '0;
              state_q <= ROUND;
            end
          end
          ROUND: begin
            h_q   <= h_d;
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'(NIBBLES - 1)) begin
              state_q <= last_q ? DONE : IDLE;
            end
          end
          DONE: begin
            digest_q <= h_q;
            dv_q     <= 1'b1;
            h_q      <= IV;
            state_q  <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign msg_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign digest       = digest_q;
  assign digest_valid = dv_q;

endmodule
